gcd_arbiter: RTL

- Shares one gcd_fsm-based GCD core between N_REQ requesters using round-robin arbitration.
- Accepts one operand pair at a time from the granted requester and drives the core's go/operand inputs.
- Captures the result and returns it on a shared response channel tagged with the requester id.
- Answers zero-operand requests directly, bypassing the core (the core never terminates on a zero operand).

---
 rtl/gcd_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one iterative GCD core among N_REQ requesters.
// Zero-operand requests are answered directly because the core never finishes on them.
module gcd_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  input  logic                   rsp_ready,
  output logic                   core_go,
  output logic [WIDTH-1:0]       core_x,
  output logic [WIDTH-1:0]       core_y,
  input  logic                   core_done,
  input  logic [WIDTH-1:0]       core_result,
  output logic                   busy
);

  localparam int SW = ID_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_RELEASE} state_t;

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic             used_core;

  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [WIDTH-1:0] grant_x;
  logic [WIDTH-1:0] grant_y;
  logic [SW-1:0]    scan_sum;
  logic [ID_W-1:0]  scan_idx;

  // Scan from the farthest offset down so the nearest valid requester to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_x   = '0;
    grant_y   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + SW'(k);
      if (scan_sum >= SW'(N_REQ)) scan_sum = scan_sum - SW'(N_REQ);
      scan_idx = scan_sum[ID_W-1:0];
      if (req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
        grant_x   = req_x[scan_idx*WIDTH +: WIDTH];
        grant_y   = req_y[scan_idx*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready = (state == S_IDLE && grant_vld) ? (N_REQ'(1) << grant_id) : '0;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      used_core <= 1'b0;
      core_go   <= 1'b0;
      core_x    <= '0;
      core_y    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            rsp_id <= grant_id;
            rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            if (grant_x == '0 || grant_y == '0) begin
              rsp_data  <= grant_x | grant_y;
              used_core <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= S_RESP;
            end else begin
              core_x    <= grant_x;
              core_y    <= grant_y;
              used_core <= 1'b1;
              core_go   <= 1'b1;
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (core_done) begin
            rsp_data  <= core_result;
            core_go   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= used_core ? S_RELEASE : S_IDLE;
          end
        end
        // The core must drop done before it can see the next go.
        S_RELEASE: begin
          if (!core_done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
